// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared state encoding and default reset vector for pc_gen
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VEC = 32'h8000_0000;

endpackage

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with boot delay, redirect and handshake increment
// Optional macro PC_MISALIGN_CHK_EN: reject misaligned redirects into a HALT state.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = XLEN'(PC_RESET_VEC),
  parameter int              INST_BYTES  = 4,
  parameter int              BOOT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  output logic            booting
`ifdef PC_MISALIGN_CHK_EN
  ,
  output logic            misalign,
  output logic [XLEN-1:0] misalign_pc
`endif
);

  localparam logic [XLEN-1:0] LOW_MASK  = XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(INST_BYTES);
  localparam logic [3:0]      BOOT_LAST = (BOOT_CYCLES == 0) ? 4'd0 : 4'(BOOT_CYCLES - 1);

  pc_state_e       state, state_nxt;
  logic [3:0]      boot_cnt, boot_cnt_nxt;
  logic            pend_vld, pend_vld_nxt;
  logic [XLEN-1:0] pend_pc, pend_pc_nxt;
  logic [XLEN-1:0] pc_q, pc_nxt;
  logic [XLEN-1:0] redir_tgt;

`ifdef PC_MISALIGN_CHK_EN
  logic            redir_bad;
  logic            mis_q, mis_nxt;
  logic [XLEN-1:0] mis_pc_q, mis_pc_nxt;

  assign redir_bad   = redirect_valid && ((redirect_pc & LOW_MASK) != '0);
  assign redir_tgt   = redirect_pc;
  assign misalign    = mis_q;
  assign misalign_pc = mis_pc_q;
`else
  // Without the checker, misaligned targets are silently rounded down.
  assign redir_tgt = redirect_pc & ~LOW_MASK;
`endif

  assign fetch_valid = (state == ST_RUN);
  assign booting     = (state == ST_BOOT);
  assign fetch_pc    = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_BOOT;
      boot_cnt <= '0;
      pend_vld <= 1'b0;
      pend_pc  <= '0;
      pc_q     <= RESET_VEC;
`ifdef PC_MISALIGN_CHK_EN
      mis_q    <= 1'b0;
      mis_pc_q <= '0;
`endif
    end else begin
      state    <= state_nxt;
      boot_cnt <= boot_cnt_nxt;
      pend_vld <= pend_vld_nxt;
      pend_pc  <= pend_pc_nxt;
      pc_q     <= pc_nxt;
`ifdef PC_MISALIGN_CHK_EN
      mis_q    <= mis_nxt;
      mis_pc_q <= mis_pc_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    boot_cnt_nxt = boot_cnt;
    pend_vld_nxt = pend_vld;
    pend_pc_nxt  = pend_pc;
    pc_nxt       = pc_q;
    case (state)
      ST_BOOT: begin
        boot_cnt_nxt = boot_cnt + 4'd1;
        if (redirect_valid) begin
          pend_vld_nxt = 1'b1;
          pend_pc_nxt  = redir_tgt;
        end
        if (boot_cnt == BOOT_LAST) begin
          state_nxt    = ST_RUN;
          boot_cnt_nxt = '0;
          pend_vld_nxt = 1'b0;
          pend_pc_nxt  = '0;
          // A redirect arriving on the final boot edge is the newest one.
          if (redirect_valid)
            pc_nxt = redir_tgt;
          else if (pend_vld)
            pc_nxt = pend_pc;
          else
            pc_nxt = RESET_VEC;
        end
      end
      ST_RUN: begin
        if (redirect_valid)
          pc_nxt = redir_tgt;
        else if (fetch_ready)
          pc_nxt = pc_q + PC_STEP;
      end
`ifdef PC_MISALIGN_CHK_EN
      ST_HALT: begin
        if (redirect_valid) begin
          state_nxt = ST_RUN;
          pc_nxt    = redir_tgt;
        end
      end
`endif
      default: state_nxt = ST_BOOT;
    endcase

`ifdef PC_MISALIGN_CHK_EN
    mis_nxt    = 1'b0;
    mis_pc_nxt = mis_pc_q;
    if (redir_bad) begin
      state_nxt    = ST_HALT;
      mis_nxt      = 1'b1;
      mis_pc_nxt   = redirect_pc;
      boot_cnt_nxt = '0;
      pend_vld_nxt = 1'b0;
      pend_pc_nxt  = '0;
      pc_nxt       = pc_q;
    end
`endif
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen (BOOT_CYCLES=1 and BOOT_CYCLES=3 instances)
// Optional macro PC_MISALIGN_CHK_EN selects the misalign checks.
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_ready = 1'b0;
  logic        a_valid, a_boot, b_valid, b_boot;
  logic [31:0] a_pc, b_pc;
`ifdef PC_MISALIGN_CHK_EN
  logic        a_mis, b_mis;
  logic [31:0] a_mis_pc, b_mis_pc;
`endif

  always #5 clk = ~clk;

  pc_gen #(.XLEN(32), .RESET_VEC(RV), .INST_BYTES(4), .BOOT_CYCLES(1)) u_a (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_ready(fetch_ready), .fetch_valid(a_valid), .fetch_pc(a_pc), .booting(a_boot)
`ifdef PC_MISALIGN_CHK_EN
    , .misalign(a_mis), .misalign_pc(a_mis_pc)
`endif
  );

  pc_gen #(.XLEN(32), .RESET_VEC(RV), .INST_BYTES(4), .BOOT_CYCLES(3)) u_b (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_ready(fetch_ready), .fetch_valid(b_valid), .fetch_pc(b_pc), .booting(b_boot)
`ifdef PC_MISALIGN_CHK_EN
    , .misalign(b_mis), .misalign_pc(b_mis_pc)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: boot countdown, last-wins pending target, then plain PC arithmetic.
  int          m_bc[2] = '{1, 3};
  bit          m_boot[2];
  int          m_edges[2];
  bit          m_has_pend[2];
  logic [31:0] m_pend[2];
  logic [31:0] m_pc[2];

  function automatic logic [31:0] align(input logic [31:0] a);
    return a - (a % 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_boot[i] = 1'b1;
      m_edges[i] = 0;
      m_has_pend[i] = 1'b0;
      m_pc[i] = RV;
    end
  endtask

  task automatic model_step(input bit rv, input logic [31:0] rpc, input bit rdy);
    for (int i = 0; i < 2; i++) begin
      if (m_boot[i]) begin
        if (rv) begin
          m_has_pend[i] = 1'b1;
          m_pend[i] = align(rpc);
        end
        m_edges[i]++;
        if (m_edges[i] >= ((m_bc[i] == 0) ? 1 : m_bc[i])) begin
          m_boot[i] = 1'b0;
          m_pc[i] = m_has_pend[i] ? m_pend[i] : RV;
          m_has_pend[i] = 1'b0;
        end
      end else if (rv) begin
        m_pc[i] = align(rpc);
      end else if (rdy) begin
        m_pc[i] = m_pc[i] + 32'd4;
      end
    end
  endtask

  task automatic check_model();
    check("rand_a_valid", {31'b0, a_valid}, {31'b0, !m_boot[0]});
    check("rand_a_boot", {31'b0, a_boot}, {31'b0, m_boot[0]});
    check("rand_b_valid", {31'b0, b_valid}, {31'b0, !m_boot[1]});
    check("rand_b_boot", {31'b0, b_boot}, {31'b0, m_boot[1]});
    if (!m_boot[0]) check("rand_a_pc", a_pc, m_pc[0]);
    if (!m_boot[1]) check("rand_b_pc", b_pc, m_pc[1]);
`ifdef PC_MISALIGN_CHK_EN
    check("rand_a_mis", {31'b0, a_mis}, 32'd0);
`endif
  endtask

  task automatic drive(input bit rv, input logic [31:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc = rpc;
    fetch_ready = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input bit rv, input logic [31:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc = rpc;
    fetch_ready = rdy;
    @(posedge clk);
    model_step(rv, rpc, rdy);
    @(negedge clk);
    check_model();
  endtask

  task automatic pulse_reset();
    redirect_valid = 1'b0;
    fetch_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async_a_valid", {31'b0, a_valid}, 32'd0);
    check("rst_async_a_pc", a_pc, RV);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit          rv;
    logic [31:0] rpc;
    bit          rdy;
    bit          ev;
    logic [31:0] epc;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0000};
    tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0004};
    tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0008};
    tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_000C};
    tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_0010};
    tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0010};
    tbl[6]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0010};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h8000_0010};
    tbl[8]  = '{1'b1, 32'h8000_1000, 1'b1, 1'b1, 32'h8000_1000};
    tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8000_1004};
    tbl[10] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFFFF_FFFC};
    tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC};
    tbl[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000};
    tbl[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_a_valid", {31'b0, a_valid}, 32'd0);
    check("reset_a_boot", {31'b0, a_boot}, 32'd1);
    check("reset_a_pc", a_pc, RV);
    check("reset_b_valid", {31'b0, b_valid}, 32'd0);
    check("reset_b_pc", b_pc, RV);
    rst = 1'b0;
    #1;
    check("release_a_boot", {31'b0, a_boot}, 32'd1);

    // Sequential fetch, stall, redirect priority, wrap-around
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), {31'b0, a_valid}, {31'b0, tbl[i].ev});
      check($sformatf("tbl%0d_boot", i), {31'b0, a_boot}, {31'b0, !tbl[i].ev});
      if (tbl[i].ev) check($sformatf("tbl%0d_pc", i), a_pc, tbl[i].epc);
    end

    // Reset asserted mid-run abandons the request immediately
    pulse_reset();

    // Two redirects during a 3-cycle boot: the later one wins
    drive(1'b1, 32'h8000_2000, 1'b0);
    check("boot3_e1_boot", {31'b0, b_boot}, 32'd1);
    check("boot3_e1_valid", {31'b0, b_valid}, 32'd0);
    drive(1'b1, 32'h8000_3000, 1'b0);
    check("boot3_e2_boot", {31'b0, b_boot}, 32'd1);
    check("boot3_e2_valid", {31'b0, b_valid}, 32'd0);
    drive(1'b0, 32'h0, 1'b0);
    check("boot3_e3_valid", {31'b0, b_valid}, 32'd1);
    check("boot3_e3_pc", b_pc, 32'h8000_3000);
    drive(1'b0, 32'h0, 1'b1);
    check("boot3_e4_pc", b_pc, 32'h8000_3004);

    // Misaligned redirect
    pulse_reset();
    drive(1'b0, 32'h0, 1'b1);
    drive(1'b1, 32'h8000_0102, 1'b1);
`ifdef PC_MISALIGN_CHK_EN
    check("mis_pulse", {31'b0, a_mis}, 32'd1);
    check("mis_pc", a_mis_pc, 32'h8000_0102);
    check("mis_halt_valid", {31'b0, a_valid}, 32'd0);
    drive(1'b0, 32'h0, 1'b1);
    check("mis_pulse_end", {31'b0, a_mis}, 32'd0);
    check("mis_halt_hold", {31'b0, a_valid}, 32'd0);
    drive(1'b1, 32'h8000_0106, 1'b1);
    check("mis_repulse", {31'b0, a_mis}, 32'd1);
    check("mis_pc2", a_mis_pc, 32'h8000_0106);
    drive(1'b1, 32'h8000_0200, 1'b1);
    check("mis_exit_valid", {31'b0, a_valid}, 32'd1);
    check("mis_exit_pc", a_pc, 32'h8000_0200);
    check("mis_exit_pulse", {31'b0, a_mis}, 32'd0);
`else
    check("mis_round_valid", {31'b0, a_valid}, 32'd1);
    check("mis_round_pc", a_pc, 32'h8000_0100);
    drive(1'b0, 32'h0, 1'b1);
    check("mis_round_next", a_pc, 32'h8000_0104);
`endif

    // Randomized traffic against the reference model
    pulse_reset();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] rpc;
      bit rv, rdy;
      rv = ($urandom_range(0, 5) == 0);
      rdy = $urandom_range(0, 1) == 1;
      rpc = $urandom;
`ifdef PC_MISALIGN_CHK_EN
      rpc = align(rpc);
`endif
      if ($urandom_range(0, 60) == 0) pulse_reset();
      else step(rv, rpc, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 32'h8000_0000, first fetch address after reset.
REQ-003 SHALL have parameter INST_BYTES, default 4, sequential increment; power of two, at least 2.
REQ-004 SHALL have parameter BOOT_CYCLES, default 1, idle cycles after reset release before first fetch; range 0..15.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port redirect_valid  input  1  redirect request this cycle.
REQ-008 SHALL have port redirect_pc  input  XLEN  redirect target.
REQ-009 SHALL have port fetch_ready  input  1  fetch unit accepts fetch_pc.
REQ-010 SHALL have port fetch_valid  output  1  fetch_pc is a valid request.
REQ-011 SHALL have port fetch_pc  output  XLEN  address being requested.
REQ-012 SHALL have port booting  output  1  high while in BOOT state.

Function
REQ-013 SHALL implement states BOOT, RUN, HALT; HALT exists only when PC_MISALIGN_CHK_EN is defined.
REQ-014 SHALL count BOOT_CYCLES clock edges in BOOT, then enter RUN; BOOT_CYCLES=0 enters RUN on the first edge after reset release.
REQ-015 SHALL drive fetch_valid high only in RUN.
REQ-016 SHALL hold fetch_pc stable while fetch_valid=1 and fetch_ready=0.
REQ-017 SHALL set fetch_pc to fetch_pc+INST_BYTES on the edge after fetch_valid&&fetch_ready, modulo 2^XLEN; wrap-around from the all-ones-aligned address to 0 is legal and silent.
REQ-018 SHALL load redirect_pc into fetch_pc on the edge after redirect_valid in RUN; redirect takes priority over the handshake increment in the same cycle.
REQ-019 SHALL, on redirect_valid in BOOT, latch redirect_pc into a pending register; the last redirect wins; the pending value is applied as fetch_pc on entering RUN instead of RESET_VEC.
REQ-020 SHALL clear the pending register on entering RUN.
REQ-021 SHALL complete a handshake in the redirect cycle; the redirected fetch_pc is presented with fetch_valid=1 in the following cycle.

Reset
REQ-022 SHALL, while rst=1, force state=BOOT, fetch_pc=RESET_VEC, fetch_valid=0, booting=1, boot counter=0, pending cleared, misalign=0.
REQ-023 SHALL, on rst assertion mid-operation, abandon any in-flight request without completing the handshake.

Configuration
REQ-024 SHALL, with macro PC_MISALIGN_CHK_EN defined, add output misalign (1 bit) and misalign_pc (XLEN).
REQ-025 SHALL, with PC_MISALIGN_CHK_EN, reject a redirect whose low log2(INST_BYTES) bits are nonzero: pulse misalign for one cycle, capture redirect_pc in misalign_pc, and enter HALT with fetch_valid=0.
REQ-026 SHALL leave HALT only on an aligned redirect, which enters RUN with fetch_pc=redirect_pc; misaligned redirects in HALT re-pulse misalign.
REQ-027 SHALL, without PC_MISALIGN_CHK_EN, clear the low log2(INST_BYTES) bits of redirect_pc and accept it; no HALT state, no misalign ports.

Structure
REQ-028 SHALL place the state enum (BOOT, RUN, HALT) and the default RESET_VEC constant in shared package pc_pkg.
REQ-029 SHALL contain no sub-modules; a single module is natural.

Verification
REQ-030 SHALL cover: reset release, BOOT_CYCLES=1, fetch_ready=1 -> fetch_valid rises one cycle after release, fetch_pc 0x80000000, then 0x80000004, 0x80000008.
REQ-031 SHALL cover: fetch_ready=0 for 3 cycles at fetch_pc 0x80000010 -> fetch_pc holds 0x80000010, fetch_valid stays 1.
REQ-032 SHALL cover: redirect_valid with redirect_pc 0x80001000 and fetch_ready=1 in the same cycle -> next fetch_pc 0x80001000, not 0x80000xx4.
REQ-033 SHALL cover: BOOT_CYCLES=3, redirect 0x80002000 then 0x80003000 during BOOT -> first fetch_pc 0x80003000.
REQ-034 SHALL cover: XLEN=32, fetch_pc 0xFFFFFFFC accepted -> fetch_pc 0x00000000.
REQ-035 SHALL cover, with PC_MISALIGN_CHK_EN: redirect 0x80000102 -> misalign one-cycle pulse, misalign_pc 0x80000102, fetch_valid 0 until redirect 0x80000200 is applied; without the macro the same redirect yields fetch_pc 0x80000100.
